// File: rtl/dpi_receiver_pkg.sv
package dpi_receiver_pkg;

    real target_rate = 1.0;
    int  expected_id = 0;
    int  get_count   = 0;
    int  bad_id      = 0;
    int  put_log[$];
    int  err_log[$];

    function automatic real getTargetRate(input int id);
        if (id != expected_id) bad_id++;
        get_count++;
        return target_rate;
    endfunction

    function automatic int putDpiReceiverData(input int id, input int data);
        if (id != expected_id) bad_id++;
        put_log.push_back(data);
        return 0;
    endfunction

    function automatic int reportDpiError(input int id, input int code);
        if (id != expected_id) bad_id++;
        err_log.push_back(code);
        return 0;
    endfunction

endpackage

// File: rtl/dpi_receiver_if.sv
// Valid/ready handshake between a producer and dpi_receiver.
interface dpi_receiver_if #(
  parameter int width = 8
);
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;

  modport master (output c_srdy, output c_data, input c_drdy);
  modport slave  (input c_srdy, input c_data, output c_drdy);
endinterface

// File: rtl/dpi_receiver.sv
// Rate-throttled receiver: every accepted word is handed to the host-side functions.
// Define DPI_RECEIVER_CHECK_EN to compile in the stall protocol checks (error codes 1 and 2).

module dpi_receiver #(
  parameter int width   = 8,
  parameter int id      = 0,
  parameter int timeout = 1000
) (
  input  logic          clk,
  input  logic          reset,
  dpi_receiver_if.slave rx,
  output logic [31:0]   xfer_count,
  output logic          err_flag
);

  import dpi_receiver_pkg::*;

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state_reg;
  logic        c_drdy_reg;
  logic        err_flag_reg;
  logic [31:0] xfer_count_reg;
  logic [31:0] stall_cnt_reg;
  real         actual_rate_reg;
  real         rate_next;
  logic        xfer;
`ifdef DPI_RECEIVER_CHECK_EN
  logic [width-1:0] held_data_reg;
  logic             data_err_done_reg;
`endif

  // Rate decays every cycle and is topped up by each accepted word.
  always_comb begin
    xfer      = rx.c_srdy && c_drdy_reg;
    rate_next = actual_rate_reg * 0.9;
    if (xfer) begin
      rate_next = rate_next + 0.1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      c_drdy_reg        <= 1'b0;
      err_flag_reg      <= 1'b0;
      xfer_count_reg    <= 32'd0;
      stall_cnt_reg     <= 32'd0;
      actual_rate_reg   <= 1.0;
`ifdef DPI_RECEIVER_CHECK_EN
      held_data_reg     <= '0;
      data_err_done_reg <= 1'b0;
`endif
    end else begin
      actual_rate_reg <= rate_next;
      c_drdy_reg      <= (rate_next <= getTargetRate(id));
      if (xfer) begin
        void'(putDpiReceiverData(id, 32'(rx.c_data)));
        xfer_count_reg <= xfer_count_reg + 32'd1;
      end
      case (state_reg)
        IDLE: begin
          if (rx.c_srdy && !xfer) begin
            state_reg         <= PEND;
            stall_cnt_reg     <= 32'd0;
`ifdef DPI_RECEIVER_CHECK_EN
            held_data_reg     <= rx.c_data;
            data_err_done_reg <= 1'b0;
`endif
          end
        end
        PEND: begin
          // Statement order fixes the report order when codes coincide.
`ifdef DPI_RECEIVER_CHECK_EN
          if ((rx.c_data != held_data_reg) && !data_err_done_reg) begin
            void'(reportDpiError(id, 1));
            data_err_done_reg <= 1'b1;
            err_flag_reg      <= 1'b1;
          end
`endif
          if (xfer) begin
            state_reg <= IDLE;
          end else if (!rx.c_srdy) begin
            state_reg <= IDLE;
`ifdef DPI_RECEIVER_CHECK_EN
            void'(reportDpiError(id, 2));
            err_flag_reg <= 1'b1;
`endif
          end else if (stall_cnt_reg != 32'(timeout)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
            // Saturation keeps this edge unique within an episode.
            if ((timeout != 0) && (stall_cnt_reg + 32'd1 == 32'(timeout))) begin
              void'(reportDpiError(id, 3));
              err_flag_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx.c_drdy  = c_drdy_reg;
  assign xfer_count = xfer_count_reg;
  assign err_flag   = err_flag_reg;

endmodule

// File: tb/tb_dpi_receiver.sv
// Directed bench for dpi_receiver; host-side functions live in dpi_receiver_pkg.

module tb_dpi_receiver;
  import dpi_receiver_pkg::*;

  localparam int TB_ID = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] xfer_count;
  logic        err_flag;

  int vectors     = 0;
  int miscompares = 0;
  int calls_snap;
  int err_snap;
  int cnt;

  dpi_receiver_if #(.width(8)) bus ();

  dpi_receiver #(
    .width  (8),
    .id     (TB_ID),
    .timeout(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (bus),
    .xfer_count(xfer_count),
    .err_flag  (err_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("vec %0d %s obs=0x%0h exp=0x%0h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int all_calls();
    return get_count + put_log.size() + err_log.size();
  endfunction

  function automatic int put_at(input int k);
    return (k < put_log.size()) ? put_log[k] : -1;
  endfunction

  function automatic int err_at(input int k);
    return (k < err_log.size()) ? err_log[k] : -1;
  endfunction

  initial begin
    expected_id = TB_ID;

    // Reset state
    reset = 1'b1; bus.c_srdy = 1'b0; bus.c_data = 8'h00; target_rate = 1.0;
    repeat (3) @(negedge clk);
    check("rst_drdy",       32'(bus.c_drdy), 32'd0);
    check("rst_xfer_count", xfer_count,      32'd0);
    check("rst_err_flag",   32'(err_flag),   32'd0);
    check("rst_dpi_calls",  32'(all_calls()), 32'd0);

    // Full rate, back-to-back stream 1..16
    reset = 1'b0; bus.c_srdy = 1'b1; bus.c_data = 8'd1;
    @(negedge clk);
    check("first_edge_drdy", 32'(bus.c_drdy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      bus.c_data = 8'(k);
      @(negedge clk);
    end
    bus.c_srdy = 1'b0;
    check("stream_xfer_count", xfer_count, 32'd16);
    check("stream_put_calls",  32'(put_log.size()), 32'd16);
    for (int k = 0; k < 16; k++) check("stream_put_value", 32'(put_at(k)), 32'(k + 1));
    check("stream_err_flag",   32'(err_flag), 32'd0);

    // Half rate, continuous srdy for 200 cycles
    reset = 1'b1;
    @(negedge clk);
    check("halfrate_rst_drdy", 32'(bus.c_drdy), 32'd0);
    reset = 1'b0; target_rate = 0.5; bus.c_srdy = 1'b1; bus.c_data = 8'h33;
    repeat (200) @(negedge clk);
    cnt = xfer_count;
    check("halfrate_count_in_90_110", 32'(cnt >= 90 && cnt <= 110), 32'd1);
    check("halfrate_err_flag",        32'(err_flag), 32'd0);

    // Watchdog: zero rate, stalled 0x55, timeout 8 (reset taken with srdy still high)
    reset = 1'b1; bus.c_data = 8'h55; target_rate = 0.0;
    @(negedge clk);
    reset = 1'b0;
    err_snap = err_log.size();
    check("wd_reset_no_error", 32'(err_snap), 32'd0);
    repeat (8) @(negedge clk);
    check("wd_before_limit", 32'(err_flag), 32'd0);
    @(negedge clk);
    check("wd_at_limit_err_flag", 32'(err_flag), 32'd1);
    check("wd_err_calls",         32'(err_log.size()), 32'd1);
    check("wd_err_code",          32'(err_at(0)), 32'd3);
    repeat (12) @(negedge clk);
    check("wd_once_per_episode",  32'(err_log.size()), 32'd1);
    check("wd_no_xfer",           xfer_count, 32'd0);

    // One-cycle reset pulse in the middle of a stall
    calls_snap = all_calls();
    reset = 1'b1;
    @(negedge clk);
    check("pulse_dpi_calls", 32'(all_calls() - calls_snap), 32'd0);
    check("pulse_drdy",      32'(bus.c_drdy), 32'd0);
    check("pulse_xfer",      xfer_count,      32'd0);
    check("pulse_err_flag",  32'(err_flag),   32'd0);
    reset = 1'b0; bus.c_srdy = 1'b0; target_rate = 1.0;

    // Transfer counter wrap
    repeat (2) @(negedge clk);
    force dut.xfer_count_reg = 32'hFFFF_FFFF;
    #1 release dut.xfer_count_reg;
    check("preset_count", xfer_count, 32'hFFFF_FFFF);
    bus.c_srdy = 1'b1; bus.c_data = 8'hA5;
    @(negedge clk);
    bus.c_srdy = 1'b0;
    check("wrap_count",     xfer_count, 32'd0);
    check("wrap_put_value", 32'(put_at(put_log.size() - 1)), 32'h0000_00A5);

    // Data change then srdy drop while stalled
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; target_rate = 0.0; bus.c_srdy = 1'b1; bus.c_data = 8'h55;
    err_snap = err_log.size();
    @(negedge clk);
    bus.c_data = 8'h56;
    @(negedge clk);
`ifdef DPI_RECEIVER_CHECK_EN
    check("chk_data_err_calls", 32'(err_log.size() - err_snap), 32'd1);
    check("chk_data_err_code",  32'(err_at(err_snap)), 32'd1);
    check("chk_data_err_flag",  32'(err_flag), 32'd1);
`else
    check("nochk_data_err_calls", 32'(err_log.size() - err_snap), 32'd0);
    check("nochk_data_err_flag",  32'(err_flag), 32'd0);
`endif
    repeat (2) @(negedge clk);
    bus.c_srdy = 1'b0;
    @(negedge clk);
`ifdef DPI_RECEIVER_CHECK_EN
    check("chk_drop_err_calls", 32'(err_log.size() - err_snap), 32'd2);
    check("chk_drop_err_code",  32'(err_at(err_snap + 1)), 32'd2);
`else
    check("nochk_drop_err_calls", 32'(err_log.size() - err_snap), 32'd0);
    check("nochk_drop_err_flag",  32'(err_flag), 32'd0);
`endif
    check("drop_no_xfer", xfer_count, 32'd0);

    check("dpi_id_argument_errors", 32'(bad_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
